// File: rtl/channel_pkg.sv
// Shared definitions for the channel arbiter and the channel receive side:
// FSM state encoding, requester-id width, and channel word field offsets.
// Channel word layout: {vld, src_id, data}, data at bit 0.
package channel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Requester-id width; a single requester still gets a one-bit id field.
  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int CH_DATA_LSB = 0;

  function automatic int ch_id_lsb(input int dwidth);
    return dwidth;
  endfunction

  function automatic int ch_vld_bit(input int nreq, input int dwidth);
    return dwidth + idw(nreq);
  endfunction

endpackage

// File: rtl/channel_arbiter_rr.sv
// Round-robin selector: purely combinational. The search starts at ptr_i
// and wraps at NREQ-1 -> 0, so non-power-of-two NREQ never aliases.
module rr_arbiter
  import channel_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic [2*NREQ-1:0] rot;
  logic              found;
  int                sum;

  // Rotate the doubled request vector so bit k is requester (ptr+k) mod NREQ.
  always_comb begin
    rot       = {req_i, req_i} >> ptr_i;
    found     = 1'b0;
    sum       = 0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_i) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        gnt_idx_o = IDW'(sum);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = found && (gnt_idx_o == IDW'(i));
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// Credit-based packet arbiter: NREQ requesters share one channel; an owner
// holds the grant for a whole packet. Optional blocked-cycle statistics are
// built only when CHANNEL_ARBITER_STATS_EN is defined.
module channel_arbiter
  import channel_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 32,
  parameter int CREDITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [idw(NREQ)+DWIDTH:0] ch_data_in,
  input  logic                     credit_ret,
  output logic                     credit_err,
  output logic [31:0]              stall_cnt
);

  localparam int IDW = idw(NREQ);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_e               state_q;
  logic [IDW-1:0]       owner_q;
  logic [IDW-1:0]       ptr_q;
  logic [CW-1:0]        credits_q;
  logic [CW-1:0]        credits_d;
  logic [IDW+DWIDTH:0]  ch_q;
  logic                 err_q;
  logic                 err_set;

  logic [NREQ-1:0]      rr_gnt;
  logic [IDW-1:0]       rr_idx;
  logic [IDW-1:0]       sel_idx;
  logic [IDW-1:0]       next_ptr;
  logic                 accept;
  logic                 acc_last;
  logic [DWIDTH-1:0]    acc_data;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx)
  );

  // Ready: round-robin grant when idle, owner only once locked; never without credit.
  always_comb begin
    req_ready = '0;
    if (rst_n && credits_q != '0) begin
      if (state_q == ST_IDLE) begin
        req_ready = rr_gnt;
      end else begin
        for (int i = 0; i < NREQ; i++) req_ready[i] = (owner_q == IDW'(i));
      end
    end
  end

  assign sel_idx  = (state_q == ST_IDLE) ? rr_idx : owner_q;
  assign accept   = |(req_valid & req_ready);
  assign next_ptr = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;

  // Mux out the selected requester's last flag and payload.
  always_comb begin
    acc_last = 1'b0;
    acc_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IDW'(i)) begin
        acc_last = req_last[i];
        acc_data = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Credit bookkeeping; a return with nothing in flight only raises the error.
  always_comb begin
    credits_d = credits_q;
    err_set   = 1'b0;
    case ({accept, credit_ret})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) err_set = 1'b1;
        else                       credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  // Ownership FSM with registered channel word, credits and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      credits_q <= CRED_MAX;
      ch_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_q | err_set;
      ch_q      <= accept ? {1'b1, sel_idx, acc_data} : '0;
      if (accept) owner_q <= sel_idx;
      if (accept && acc_last) begin
        state_q <= ST_IDLE;
        ptr_q   <= next_ptr;
      end else if (accept || state_q != ST_IDLE) begin
        // Locked owner: STALL exactly while the credit count is zero.
        state_q <= (credits_d == '0) ? ST_STALL : ST_BURST;
      end
    end
  end

  assign ch_data_in = ch_q;
  assign credit_err = err_q;

`ifdef CHANNEL_ARBITER_STATS_EN
  logic [31:0] stall_q;

  // Count cycles with pending requests but no credit, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (|req_valid && credits_q == '0 && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_channel_arbiter.sv
// Scoreboard bench for channel_arbiter: two instances (CREDITS=8 and 2).
// Stimulus pushes expected channel words; negedge monitors pop and compare.
module tb_channel_arbiter;
  import channel_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int CWW  = 1 + IDW + DW;
  localparam int VLD  = DW + IDW;
`ifdef CHANNEL_ARBITER_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 a_rst_n, a_ret, a_err, b_rst_n, b_ret, b_err;
  logic [NREQ-1:0]      a_valid, a_last, a_ready, b_valid, b_last, b_ready;
  logic [NREQ*DW-1:0]   a_data, b_data;
  logic [CWW-1:0]       a_ch, b_ch, ea, eb;
  logic [31:0]          a_stall, b_stall;

  int n_checks = 0;
  int n_pass   = 0;
  int seq      = 0;
  logic [CWW-1:0] qa[$];
  logic [CWW-1:0] qb[$];

  channel_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .CREDITS(8)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_last(a_last),
    .req_data(a_data), .req_ready(a_ready), .ch_data_in(a_ch),
    .credit_ret(a_ret), .credit_err(a_err), .stall_cnt(a_stall)
  );

  channel_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .CREDITS(2)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_last(b_last),
    .req_data(b_data), .req_ready(b_ready), .ch_data_in(b_ch),
    .credit_ret(b_ret), .credit_err(b_err), .stall_cnt(b_stall)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic fill(output logic [NREQ*DW-1:0] d);
    seq++;
    for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = (32'(i) << 28) | 32'(seq);
  endtask

  function automatic logic [CWW-1:0] word(input int idx, input logic [NREQ*DW-1:0] d);
    return {1'b1, IDW'(idx), d[idx*DW +: DW]};
  endfunction

  task automatic step_a(input string nm, input logic rst, input logic [3:0] v,
                        input logic [3:0] l, input logic ret, input logic [3:0] rdy);
    logic [NREQ*DW-1:0] d;
    @(posedge clk); #1;
    fill(d);
    a_rst_n = rst; a_valid = v; a_last = l; a_ret = ret; a_data = d;
    #1;
    chk({nm, " ready"}, 64'(a_ready), 64'(rdy));
    for (int i = 0; i < NREQ; i++) if (rdy[i] && v[i]) qa.push_back(word(i, d));
  endtask

  task automatic step_b(input string nm, input logic [3:0] v, input logic [3:0] l,
                        input logic ret, input logic [3:0] rdy);
    logic [NREQ*DW-1:0] d;
    @(posedge clk); #1;
    fill(d);
    b_rst_n = 1'b1; b_valid = v; b_last = l; b_ret = ret; b_data = d;
    #1;
    chk({nm, " ready"}, 64'(b_ready), 64'(rdy));
    for (int i = 0; i < NREQ; i++) if (rdy[i] && v[i]) qb.push_back(word(i, d));
  endtask

  always @(negedge clk) begin
    if (a_ch[VLD]) begin
      if (qa.size() == 0) chk("a_ch unexpected word", 64'(a_ch), 64'(0));
      else begin
        ea = qa.pop_front();
        chk("a_ch word", 64'(a_ch), 64'(ea));
      end
    end
    if (b_ch[VLD]) begin
      if (qb.size() == 0) chk("b_ch unexpected word", 64'(b_ch), 64'(0));
      else begin
        eb = qb.pop_front();
        chk("b_ch word", 64'(b_ch), 64'(eb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    a_rst_n = 1'b0; a_valid = 4'b0101; a_last = '0; a_ret = 1'b0; a_data = '0;
    b_rst_n = 1'b0; b_valid = 4'b0001; b_last = '0; b_ret = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("a_rst ready", 64'(a_ready), 0);
    chk("a_rst ch", 64'(a_ch), 0);
    chk("a_rst err", 64'(a_err), 0);
    chk("a_rst stall", 64'(a_stall), 0);
    chk("b_rst ready", 64'(b_ready), 0);

    // Alternating single-word packets from requesters 0 and 2.
    for (int c = 0; c < 5; c++)
      step_a($sformatf("t1_c%0d", c), 1'b1, 4'b0101, 4'b1111, 1'b1,
             (c % 2 == 0) ? 4'b0001 : 4'b0100);

    // Requester 1 three-word packet with a bubble; requester 3 waits.
    step_a("t2_w0",     1'b1, 4'b1010, 4'b1000, 1'b1, 4'b0010);
    step_a("t2_w1",     1'b1, 4'b1010, 4'b1000, 1'b1, 4'b0010);
    step_a("t2_bubble", 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0010);
    step_a("t2_w2",     1'b1, 4'b1010, 4'b1010, 1'b1, 4'b0010);
    step_a("t2_r3",     1'b1, 4'b1000, 4'b1000, 1'b1, 4'b1000);
    step_a("t2_idle",   1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Reset in the middle of a packet from requester 2.
    step_a("t5_p1",    1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010);
    step_a("t5_w0",    1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100);
    step_a("t5_rst",   1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000);
    step_a("t5_after", 1'b1, 4'b0110, 4'b0110, 1'b0, 4'b0010);
    chk("t5 ch after reset", 64'(a_ch), 0);
    step_a("t5_ret1",  1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step_a("t5_ret2",  1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("t5 err before overflow", 64'(a_err), 0);
    step_a("t5_idle",  1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("t5 err after overflow", 64'(a_err), 1);
    chk("a stall_cnt", 64'(a_stall), 0);

    // CREDITS=2: five-word packet, stall, one credit releases one word.
    step_b("b_w0", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    step_b("b_w1", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    for (int c = 0; c < 9; c++)
      step_b($sformatf("b_stall%0d", c), 4'b0001, 4'b0000, 1'b0, 4'b0000);
    step_b("b_ret",       4'b0001, 4'b0000, 1'b1, 4'b0000);
    step_b("b_w2",        4'b0001, 4'b0000, 1'b0, 4'b0001);
    chk("b stall_cnt", 64'(b_stall), 64'(EXP_STALL));
    step_b("b_after_one", 4'b0001, 4'b0000, 1'b1, 4'b0000);
    step_b("b_w3_ret",    4'b0001, 4'b0000, 1'b1, 4'b0001);
    step_b("b_w4_ret",    4'b0001, 4'b0001, 1'b1, 4'b0001);
    step_b("b_ret_full0", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step_b("b_ret_full1", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("b err before overflow", 64'(b_err), 0);
    step_b("b_hold",      4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("b err set", 64'(b_err), 1);
    step_b("b_hold2",     4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("b err sticky", 64'(b_err), 1);

    repeat (2) @(posedge clk);
    #2;
    chk("qa drained", 64'(qa.size()), 0);
    chk("qb drained", 64'(qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..16).
REQ-002 Parameter DWIDTH, default 32: payload width per requester.
REQ-003 Parameter CREDITS, default 8: maximum words in flight toward the channel receiver (1..255).
REQ-004 The block SHALL have one clock, clk; reset rst_n is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester word valid.
REQ-008 req_last  in  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_data  in  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH].
REQ-010 req_ready  out  NREQ  one-hot or zero; word i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-011 ch_data_in  out  1+IDW+DWIDTH  channel input word {vld, src_id, data}; IDW = clog2(NREQ).
REQ-012 credit_ret  in  1  one-cycle pulse from receiver freeing one slot.
REQ-013 credit_err  out  1  sticky flag, credit return with no word in flight.
REQ-014 stall_cnt  out  32  blocked-cycle counter (see Configuration).

Function
REQ-015 FSM states: IDLE (no owner), BURST (owner locked), STALL (owner locked, zero credits).
REQ-016 IDLE: if credits > 0 and any req_valid, grant via round-robin starting at the index after the last granted; go to BURST the same cycle, so the first word is accepted the cycle the request is seen.
REQ-017 BURST: req_ready is asserted only for the owner while credits > 0; other requesters see ready low until the owner's accepted word has req_last=1.
REQ-018 Accepted word with req_last=1: return to IDLE next cycle; the round-robin pointer advances to owner+1 mod NREQ.
REQ-019 Credits reach 0 while owner mid-packet: go to STALL, owner ready low; return to BURST on the first cycle credits > 0.
REQ-020 ch_data_in SHALL be registered: one cycle after acceptance it carries {1, owner id, data}; on every other cycle it is all-zero.
REQ-021 Credit counter: decrement on acceptance, increment on credit_ret, unchanged when both occur in one cycle; range 0..CREDITS.
REQ-022 credit_ret with counter == CREDITS and no acceptance: counter unchanged, credit_err set until reset.
REQ-023 An owner dropping req_valid mid-packet keeps the grant (bubbles allowed); no timeout.
REQ-024 NREQ not a power of two: the pointer wraps at NREQ-1 -> 0, never at 2^IDW.

Reset
REQ-025 With rst_n low at a rising edge: state IDLE, pointer 0, credits = CREDITS, ch_data_in = 0, credit_err = 0, stall_cnt = 0; req_ready is combinational and is 0 while rst_n is low.
REQ-026 Reset mid-packet SHALL abandon the packet with no further channel words; words already in the channel are not tracked.

Configuration
REQ-027 With macro CHANNEL_ARBITER_STATS_EN defined: stall_cnt counts cycles where any req_valid is high and credits == 0, saturating at 2^32-1.
REQ-028 With the macro undefined: stall_cnt is tied to 0 and no counter logic exists.

Structure
REQ-029 Shared package channel_pkg SHALL hold the FSM state enum, the IDW width function, and the channel word field offsets (VLD, ID, DATA) for use by the receive side.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (request vector plus pointer in, one-hot grant plus index out, purely combinational).

Verification
REQ-031 Requesters 0 and 2 each send 1-word packets continuously, CREDITS=8, credit_ret every cycle -> grants alternate 0, 2, 0, 2; ch_data_in src_id matches, one cycle after acceptance.
REQ-032 Requester 1 sends a 3-word packet while 3 is valid -> 3 sees ready low until 1's last word is accepted, then is granted the next cycle.
REQ-033 CREDITS=2, no credit_ret, 5-word packet -> 2 words accepted, state STALL, ready low; one credit_ret pulse -> exactly one more word accepted.
REQ-034 Acceptance and credit_ret in the same cycle at credits=1 -> credits stays 1; credit_ret at credits=CREDITS -> credit_err=1 and stays 1.
REQ-035 rst_n low for 1 cycle mid-packet -> next cycle credits=CREDITS, state IDLE, ch_data_in=0, pointer=0.
REQ-036 CHANNEL_ARBITER_STATS_EN defined, credits 0 with requests for 10 cycles -> stall_cnt=10; macro undefined -> stall_cnt=0.
